// File: rtl/systolic_feeder.sv
// Weight-stationary array feeder: loads a weight tile row by row, then
// streams diagonally skewed activations and flushes the array.
module systolic_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [COLS*DATA_WIDTH-1:0] w_data,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] a_data,
  input  logic                       a_last,
  output logic [COLS*DATA_WIDTH-1:0] weight_out,
  output logic [ROWS-1:0]            load_weight_row,
  output logic [ROWS*DATA_WIDTH-1:0] act_out,
  output logic [ROWS-1:0]            act_valid_row,
  output logic                       busy,
  output logic                       done
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(ROWS + COLS) + 1;
  localparam int FL = ROWS + COLS - 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_W,
    STREAM,
    FLUSH
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             push_v;
  logic [ROWS*DW-1:0] push_d;

  assign w_ready = (state == LOAD_W);
  assign a_ready = (state == STREAM);
  assign busy    = (state != IDLE);
  assign push_v  = (state == STREAM) && a_valid;
  assign push_d  = push_v ? a_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      weight_out      <= '0;
      load_weight_row <= '0;
      done            <= 1'b0;
    end else begin
      load_weight_row <= '0;
      done            <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD_W;
            cnt   <= '0;
          end
        end
        LOAD_W: begin
          if (w_valid) begin
            weight_out      <= w_data;
            load_weight_row <= ROWS'(1) << cnt;
            if (cnt == CW'(ROWS - 1)) begin
              state <= STREAM;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        STREAM: begin
          if (a_valid && a_last) begin
            state <= FLUSH;
            cnt   <= '0;
          end
        end
        FLUSH: begin
          if (cnt == CW'(FL - 1)) begin
            state <= IDLE;
            done  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Row r keeps its own r+1 deep delay line, giving the diagonal skew.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DW-1:0] pd [r+1];
    logic [r:0]    pv;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k <= r; k++) pd[k] <= '0;
        pv <= '0;
      end else begin
        pd[0] <= push_d[r*DW +: DW];
        pv[0] <= push_v;
        for (int k = 1; k <= r; k++) begin
          pd[k] <= pd[k-1];
          pv[k] <= pv[k-1];
        end
      end
    end

    assign act_out[r*DW +: DW] = pd[r];
    assign act_valid_row[r]    = pv[r];
  end

endmodule
